// File: rtl/adc_capture_if.sv
// Readout stream interface for adc_capture: 28-bit {A,B} sample-pair beats
// with valid/ready handshake and an end-of-block marker.
interface adc_capture_if;
    logic        rd_valid;
    logic        rd_ready;
    logic [27:0] rd_data;
    logic        rd_last;

    modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/adc_capture.sv
// adc_capture: triggered dual-channel ADC acquisition into on-chip RAM, with
// valid/ready readout of the captured block of DEPTH = 2**ADDR_W A/B pairs.
// Optional build macro ADC_CAPTURE_OTR_SAT_EN: samples flagged out-of-range
// are replaced by full-scale values before being stored.
module adc_capture #(
    parameter int ADDR_W = 10
) (
    input  logic               CLK_65,
    input  logic               rst,
    input  logic [13:0]        ADC_DA,
    input  logic [13:0]        ADC_DB,
    input  logic               ADC_OTR_A,
    input  logic               ADC_OTR_B,
    input  logic               arm,
    input  logic               trig_force,
    input  logic signed [13:0] trig_level,
    output logic               busy,
    output logic               done,
    output logic               otr_a_sticky,
    output logic               otr_b_sticky,
    adc_capture_if.master      rd
);
    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_READOUT} state_t;

    state_t             r_state;
    state_t             w_state_next;

    // Input pipeline: stage 1 raw pins, stage 2 two's-complement samples
    logic [13:0]        r_da1, r_db1;
    logic               r_otra1, r_otrb1;
    logic signed [13:0] r_sa, r_sb;
    logic               r_otra2, r_otrb2;

    // Trigger history and capture bookkeeping
    logic signed [13:0] r_prev_a;
    logic               r_prev_valid;
    logic [ADDR_W-1:0]  r_waddr;
    logic               r_otr_a_sticky, r_otr_b_sticky;

    // Sample buffer and two-stage readout pipeline (RAM register, output register)
    logic [27:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_raddr;
    logic               r_issue_done;
    logic [27:0]        r_m_data;
    logic               r_m_valid, r_m_last;
    logic [27:0]        r_rd_data;
    logic               r_rd_valid, r_rd_last;
    logic               r_done;

    logic               w_arm_acc, w_trig, w_level_hit, w_we;
    logic [ADDR_W-1:0]  w_waddr;
    logic [13:0]        w_wr_a, w_wr_b;
    logic               w_beat, w_out_adv, w_m_adv, w_issue;

    // Rising crossing on channel A; needs one prior sample seen while armed
    assign w_level_hit = r_prev_valid && (r_prev_a < trig_level) && (r_sa >= trig_level);

`ifdef ADC_CAPTURE_OTR_SAT_EN
    // Converted MSB is the inverse of raw[13]: raw high -> +8191, raw low -> -8192
    assign w_wr_a = r_otra2 ? (r_sa[13] ? 14'h2000 : 14'h1FFF) : r_sa;
    assign w_wr_b = r_otrb2 ? (r_sb[13] ? 14'h2000 : 14'h1FFF) : r_sb;
`else
    assign w_wr_a = r_sa;
    assign w_wr_b = r_sb;
`endif

    // The triggering pair goes to address 0; CAPTURE continues from 1
    assign w_we    = w_trig || (r_state == S_CAPTURE);
    assign w_waddr = (r_state == S_CAPTURE) ? r_waddr : '0;

    assign w_beat    = r_rd_valid && rd.rd_ready;
    assign w_out_adv = !r_rd_valid || rd.rd_ready;
    assign w_m_adv   = !r_m_valid || w_out_adv;
    assign w_issue   = (r_state == S_READOUT) && !r_issue_done && w_m_adv;

    // Register ADC pins, then convert offset binary to two's complement
    always_ff @(posedge CLK_65) begin
        if (rst) begin
            r_da1   <= '0;
            r_db1   <= '0;
            r_otra1 <= 1'b0;
            r_otrb1 <= 1'b0;
            r_sa    <= '0;
            r_sb    <= '0;
            r_otra2 <= 1'b0;
            r_otrb2 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each stage take the previous stage's old value.
            r_da1   <= ADC_DA;
            r_db1   <= ADC_DB;
            r_otra1 <= ADC_OTR_A;
            r_otrb1 <= ADC_OTR_B;
            r_sa    <= {~r_da1[13], r_da1[12:0]};
            r_sb    <= {~r_db1[13], r_db1[12:0]};
            r_otra2 <= r_otra1;
            r_otrb2 <= r_otrb1;
        end
    end

    // State register
    always_ff @(posedge CLK_65) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic and per-cycle strobes
    always_comb begin
        // NOTE: defaults first so every path assigns every variable and no latch is inferred.
        w_state_next = r_state;
        w_arm_acc    = 1'b0;
        w_trig       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (arm) begin
                    w_arm_acc    = 1'b1;
                    w_state_next = S_ARMED;
                end
            end
            S_ARMED: begin
                if (trig_force || w_level_hit) begin
                    w_trig       = 1'b1;
                    w_state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (r_waddr == LAST_ADDR) w_state_next = S_READOUT;
            end
            S_READOUT: begin
                if (w_beat && r_rd_last) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Trigger history, write address and overrange sticky flags
    always_ff @(posedge CLK_65) begin
        if (rst) begin
            r_prev_a       <= '0;
            r_prev_valid   <= 1'b0;
            r_waddr        <= '0;
            r_otr_a_sticky <= 1'b0;
            r_otr_b_sticky <= 1'b0;
        end else begin
            if (w_arm_acc) begin
                r_prev_a       <= '0;
                r_prev_valid   <= 1'b0;
                r_otr_a_sticky <= 1'b0;
                r_otr_b_sticky <= 1'b0;
            end
            if (r_state == S_ARMED) begin
                r_prev_a     <= r_sa;
                r_prev_valid <= 1'b1;
            end
            if (w_trig)                      r_waddr <= ADDR_ONE;
            else if (r_state == S_CAPTURE)   r_waddr <= r_waddr + ADDR_ONE;
            if (w_we && r_otra2) r_otr_a_sticky <= 1'b1;
            if (w_we && r_otrb2) r_otr_b_sticky <= 1'b1;
        end
    end

    // Sample buffer: write port for capture, registered read port for readout
    always_ff @(posedge CLK_65) begin
        // NOTE: the buffer is not reset; nothing is read before a full capture rewrites it.
        if (w_we)    r_mem[w_waddr] <= {w_wr_a, w_wr_b};
        if (w_issue) r_m_data       <= r_mem[r_raddr];
    end

    // Readout pipeline: issue reads in address order, stall as a whole on backpressure
    always_ff @(posedge CLK_65) begin
        if (rst) begin
            r_raddr      <= '0;
            r_issue_done <= 1'b0;
            r_m_valid    <= 1'b0;
            r_m_last     <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_rd_data    <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= (r_state == S_READOUT) && w_beat && r_rd_last;
            if (r_state != S_READOUT) begin
                r_raddr      <= '0;
                r_issue_done <= 1'b0;
                r_m_valid    <= 1'b0;
                r_m_last     <= 1'b0;
                r_rd_valid   <= 1'b0;
                r_rd_last    <= 1'b0;
            end else begin
                if (w_m_adv) begin
                    r_m_valid <= w_issue;
                    r_m_last  <= w_issue && (r_raddr == LAST_ADDR);
                end
                if (w_issue) begin
                    r_raddr <= r_raddr + ADDR_ONE;
                    if (r_raddr == LAST_ADDR) r_issue_done <= 1'b1;
                end
                if (w_out_adv) begin
                    r_rd_valid <= r_m_valid;
                    r_rd_last  <= r_m_valid && r_m_last;
                    if (r_m_valid) r_rd_data <= r_m_data;
                end
            end
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign otr_a_sticky = r_otr_a_sticky;
    assign otr_b_sticky = r_otr_b_sticky;
    assign rd.rd_valid  = r_rd_valid;
    assign rd.rd_data   = r_rd_data;
    assign rd.rd_last   = r_rd_last;
endmodule

// File: tb/tb_adc_capture.sv
// Directed testbench for adc_capture (ADDR_W = 10, DEPTH = 1024).
module tb_adc_capture;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic               CLK_65 = 1'b0;
    logic               rst;
    logic [13:0]        ADC_DA, ADC_DB;
    logic               ADC_OTR_A, ADC_OTR_B;
    logic               arm, trig_force;
    logic signed [13:0] trig_level;
    logic               busy, done, otr_a_sticky, otr_b_sticky;

    adc_capture_if rd_if();

    adc_capture #(.ADDR_W(ADDR_W)) dut (
        .CLK_65      (CLK_65),
        .rst         (rst),
        .ADC_DA      (ADC_DA),
        .ADC_DB      (ADC_DB),
        .ADC_OTR_A   (ADC_OTR_A),
        .ADC_OTR_B   (ADC_OTR_B),
        .arm         (arm),
        .trig_force  (trig_force),
        .trig_level  (trig_level),
        .busy        (busy),
        .done        (done),
        .otr_a_sticky(otr_a_sticky),
        .otr_b_sticky(otr_b_sticky),
        .rd          (rd_if)
    );

    always #5 CLK_65 = ~CLK_65;

    int checks = 0;
    int errors = 0;

    logic [27:0] beat_data [DEPTH];
    logic        beat_last [DEPTH];
    int          n_beats, n_done, stall_viol, n_last, valid_after, first_valid;

    task automatic tick(input int n);
        repeat (n) @(negedge CLK_65);
    endtask

    task automatic pulse_arm();
        @(negedge CLK_65); arm = 1'b1;
        @(negedge CLK_65); arm = 1'b0;
    endtask

    task automatic pulse_force();
        @(negedge CLK_65); trig_force = 1'b1;
        @(negedge CLK_65); trig_force = 1'b0;
    endtask

    // Drain one readout block, recording beats, done pulses and stall stability
    task automatic collect(input bit toggle);
        logic [27:0] hold_data;
        logic        hold_last;
        bit          have_hold;
        int          post;
        n_beats = 0; n_done = 0; stall_viol = 0; n_last = 0;
        valid_after = 0; first_valid = -1; have_hold = 0; post = 0;
        hold_data = '0; hold_last = 1'b0;
        rd_if.rd_ready = 1'b0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge CLK_65);
            if (done) n_done++;
            if (have_hold && (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== hold_data ||
                              rd_if.rd_last !== hold_last)) stall_viol++;
            have_hold = 0;
            if (n_beats >= DEPTH) begin
                if (rd_if.rd_valid) valid_after++;
                post++;
                if (post >= 3) break;
            end else begin
                rd_if.rd_ready = toggle ? ~rd_if.rd_ready : 1'b1;
                if (rd_if.rd_valid && first_valid < 0) first_valid = cyc + 1;
                if (rd_if.rd_valid && rd_if.rd_ready) begin
                    beat_data[n_beats] = rd_if.rd_data;
                    beat_last[n_beats] = rd_if.rd_last;
                    if (rd_if.rd_last) n_last++;
                    n_beats++;
                end else if (rd_if.rd_valid) begin
                    have_hold = 1;
                    hold_data = rd_if.rd_data;
                    hold_last = rd_if.rd_last;
                end
            end
        end
        rd_if.rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ADC_DA = 14'($urandom); ADC_DB = 14'($urandom);
            ADC_OTR_A = 1'($urandom); ADC_OTR_B = 1'($urandom);
            arm = 1'($urandom); trig_force = 1'($urandom);
            trig_level = 14'($urandom); rd_if.rd_ready = 1'($urandom);
            @(negedge CLK_65);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (otr_a_sticky !== 1'b0) begin errors++; $display("FAIL reset_otr_a: got %b expected 0", otr_a_sticky); end
        checks++; if (otr_b_sticky !== 1'b0) begin errors++; $display("FAIL reset_otr_b: got %b expected 0", otr_b_sticky); end
        checks++; if (rd_if.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_if.rd_valid); end
        checks++; if (rd_if.rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last: got %b expected 0", rd_if.rd_last); end
        checks++; if (rd_if.rd_data !== 28'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_if.rd_data); end
        rst = 1'b0; arm = 1'b0; trig_force = 1'b0; rd_if.rd_ready = 1'b0;
        ADC_OTR_A = 1'b0; ADC_OTR_B = 1'b0; trig_level = 14'sd0;
        @(negedge CLK_65);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_conversion();
        ADC_DA = 14'h3FFF; ADC_DB = 14'h0000;
        tick(3);
        pulse_arm();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL conv_armed_busy: got %b expected 1", busy); end
        pulse_force();
        collect(0);
        checks++; if (first_valid !== 1025) begin errors++; $display("FAIL conv_first_valid_latency: got %0d expected 1025", first_valid); end
        checks++; if (n_beats !== DEPTH) begin errors++; $display("FAIL conv_beats: got %0d expected %0d", n_beats, DEPTH); end
        checks++; if (beat_data[0] !== {14'h1FFF, 14'h2000}) begin errors++; $display("FAIL conv_beat0: got %h expected %h", beat_data[0], {14'h1FFF, 14'h2000}); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL conv_done_count: got %0d expected 1", n_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL conv_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_level_trigger();
        trig_level = 14'sd0;
        ADC_DA = 14'h1FF0; ADC_DB = 14'h2ABC;
        tick(3);
        pulse_arm();
        fork
            begin
                for (int i = 0; i < 1100; i++) begin
                    @(negedge CLK_65);
                    ADC_DA = ADC_DA + 14'd1;
                end
            end
            collect(0);
        join
        checks++; if (n_beats !== DEPTH) begin errors++; $display("FAIL level_beats: got %0d expected %0d", n_beats, DEPTH); end
        checks++; if (beat_data[0] !== {14'h0000, 14'h0ABC}) begin errors++; $display("FAIL level_beat0: got %h expected %h", beat_data[0], {14'h0000, 14'h0ABC}); end
        checks++; if (beat_data[1][27:14] !== 14'h0001) begin errors++; $display("FAIL level_beat1_a: got %h expected 0001", beat_data[1][27:14]); end
        checks++; if (beat_data[DEPTH-1][27:14] !== 14'h03FF) begin errors++; $display("FAIL level_beat_last_a: got %h expected 03ff", beat_data[DEPTH-1][27:14]); end
        checks++; if (beat_last[DEPTH-1] !== 1'b1) begin errors++; $display("FAIL level_last_flag: got %b expected 1", beat_last[DEPTH-1]); end
        checks++; if (beat_last[DEPTH-2] !== 1'b0) begin errors++; $display("FAIL level_early_last: got %b expected 0", beat_last[DEPTH-2]); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL level_done_count: got %0d expected 1", n_done); end
    endtask

    task automatic test_overrange();
        logic [13:0] exp_a;
`ifdef ADC_CAPTURE_OTR_SAT_EN
        exp_a = 14'h2000;
`else
        exp_a = 14'h2005;
`endif
        trig_level = 14'sd0;
        ADC_DA = 14'h0005; ADC_OTR_A = 1'b1; ADC_DB = 14'h2000; ADC_OTR_B = 1'b0;
        tick(3);
        pulse_arm();
        tick(5);
        checks++; if (otr_a_sticky !== 1'b0) begin errors++; $display("FAIL otr_sticky_before_capture: got %b expected 0", otr_a_sticky); end
        pulse_force();
        collect(0);
        checks++; if (beat_data[0][27:14] !== exp_a) begin errors++; $display("FAIL otr_stored_a: got %h expected %h", beat_data[0][27:14], exp_a); end
        checks++; if (beat_data[0][13:0] !== 14'h0000) begin errors++; $display("FAIL otr_stored_b: got %h expected 0000", beat_data[0][13:0]); end
        checks++; if (otr_a_sticky !== 1'b1) begin errors++; $display("FAIL otr_a_sticky_set: got %b expected 1", otr_a_sticky); end
        checks++; if (otr_b_sticky !== 1'b0) begin errors++; $display("FAIL otr_b_sticky_clear: got %b expected 0", otr_b_sticky); end
        ADC_OTR_A = 1'b0;
        pulse_arm();
        checks++; if (otr_a_sticky !== 1'b0) begin errors++; $display("FAIL otr_rearm_clears: got %b expected 0", otr_a_sticky); end
        @(negedge CLK_65); rst = 1'b1;
        @(negedge CLK_65); rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL otr_rst_from_armed: got %b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        int bad;
        trig_level = 14'sd100;
        ADC_DA = 14'h205A; ADC_DB = 14'h1234;
        tick(3);
        pulse_arm();
        fork
            begin
                for (int i = 0; i < 1100; i++) begin
                    @(negedge CLK_65);
                    ADC_DA = ADC_DA + 14'd1;
                end
            end
            collect(1);
        join
        bad = 0;
        for (int i = 0; i < DEPTH; i++)
            if (beat_data[i] !== {14'(100 + i), 14'h3234}) bad++;
        checks++; if (n_beats !== DEPTH) begin errors++; $display("FAIL bp_beats: got %0d expected %0d", n_beats, DEPTH); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_order: got %0d wrong beats expected 0", bad); end
        checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes expected 0", stall_viol); end
        checks++; if (n_last !== 1) begin errors++; $display("FAIL bp_last_count: got %0d expected 1", n_last); end
        checks++; if (beat_last[DEPTH-1] !== 1'b1) begin errors++; $display("FAIL bp_last_pos: got %b expected 1", beat_last[DEPTH-1]); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL bp_done_count: got %0d expected 1", n_done); end
        checks++; if (valid_after !== 0) begin errors++; $display("FAIL bp_valid_after_last: got %0d expected 0", valid_after); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_abuse();
        int nv;
        // trig_force while idle
        pulse_force();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abuse_force_idle: got %b expected 0", busy); end
        tick(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abuse_force_idle_later: got %b expected 0", busy); end

        // arm during capture
        trig_level = 14'sd0; ADC_DA = 14'h3FFF; ADC_DB = 14'h0000;
        tick(3);
        pulse_arm();
        pulse_force();
        tick(10);
        pulse_arm();
        collect(0);
        checks++; if (n_beats !== DEPTH) begin errors++; $display("FAIL abuse_arm_capture_beats: got %0d expected %0d", n_beats, DEPTH); end
        checks++; if (first_valid !== 1013) begin errors++; $display("FAIL abuse_arm_capture_latency: got %0d expected 1013", first_valid); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL abuse_arm_capture_done: got %0d expected 1", n_done); end

        // reset in the middle of a capture
        pulse_arm();
        pulse_force();
        tick(499);
        rst = 1'b1;
        @(negedge CLK_65); rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abuse_rst_capture_busy: got %b expected 0", busy); end
        nv = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge CLK_65);
            if (rd_if.rd_valid || done) nv++;
        end
        checks++; if (nv !== 0) begin errors++; $display("FAIL abuse_rst_capture_no_valid: got %0d cycles expected 0", nv); end

        // first sample after arming has no history, so a constant above level never triggers
        trig_level = 14'sd1; ADC_DA = 14'h2005;
        tick(3);
        pulse_arm();
        nv = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge CLK_65);
            if (rd_if.rd_valid) nv++;
        end
        checks++; if (nv !== 0) begin errors++; $display("FAIL abuse_no_history_trigger: got %0d valid cycles expected 0", nv); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abuse_still_armed: got %b expected 1", busy); end
        @(negedge CLK_65); rst = 1'b1;
        @(negedge CLK_65); rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abuse_rst_armed: got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_conversion();
        test_level_trigger();
        test_overrange();
        test_backpressure();
        test_abuse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
